mix_col_seq: RTL and testbench

- Iterative, handshaked AES MixColumns / InvMixColumns engine for the round datapath.
- Accepts one 128-bit state and processes COLS_PER_CYCLE 32-bit columns per clock using shared GF(2^8) constant multipliers.
- Returns the transformed state with a valid/ready handshake.
- Adds over the combinational column mixer: inverse mode, area/latency trade-off, registered output with backpressure.

---
 rtl/mix_col_seq_if.sv | 21 ++
 rtl/mix_col_seq.sv | 118 +++++++++++
 tb/tb_mix_col_seq.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mix_col_seq_if.sv
// rtl/mix_col_seq_if.sv - handshake bundle between a state producer and the MixColumns engine
interface mix_col_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [127:0] mix_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] mix_out;
  logic         busy;

  modport slave (
    input  in_valid, mode, mix_in, out_ready,
    output in_ready, out_valid, mix_out, busy
  );

  modport master (
    output in_valid, mode, mix_in, out_ready,
    input  in_ready, out_valid, mix_out, busy
  );
endinterface

// File: rtl/mix_col_seq.sv
// rtl/mix_col_seq.sv - iterative AES MixColumns / InvMixColumns engine
// Mixes COLS_PER_CYCLE columns per clock in place, result held until out_ready.
module mix_col_seq #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  mix_col_seq_if.slave bus
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_col_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // COL_STEP is 0 when all four columns go at once; the 2-bit counter just stays at 0.
  localparam logic [1:0] COL_STEP  = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_BASE = 2'(4 - COLS_PER_CYCLE);

  state_t       state_q, state_d;
  logic [127:0] work_q, work_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic         mode_q, mode_d;
  logic [1:0]   idx;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] b  [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      m2[i] = xt(a[i]);
      m3[i] = m2[i] ^ a[i];
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
      m9[i] = m8[i] ^ a[i];
      mb[i] = m9[i] ^ m2[i];
      md[i] = m9[i] ^ m4[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    for (int r = 0; r < 4; r++) begin
      if (inv)
        b[r] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
      else
        b[r] = m2[r] ^ m3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    col_cnt_d     = col_cnt_q;
    mode_d        = mode_q;
    idx           = col_cnt_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          work_d    = bus.mix_in;
          mode_d    = INV_EN ? bus.mode : 1'b0;
          col_cnt_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        bus.busy = 1'b1;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          idx = col_cnt_q + 2'(i);
          work_d[32*idx +: 32] = mix_col(work_q[32*idx +: 32], mode_q);
        end
        col_cnt_d = col_cnt_q + COL_STEP;
        if (col_cnt_q == LAST_BASE)
          state_d = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mix_out = work_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      col_cnt_q <= 2'd0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      col_cnt_q <= col_cnt_d;
      mode_q    <= mode_d;
    end
  end

endmodule

// File: tb/tb_mix_col_seq.sv
// tb/tb_mix_col_seq.sv - randomized self-checking bench for mix_col_seq
// Instances: 0 = 1 col/clk, 1 = 2 col/clk, 2 = 4 col/clk, 3 = 1 col/clk forward only.
module tb_mix_col_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic         in_valid_v  [4];
  logic         mode_v      [4];
  logic [127:0] mix_in_v    [4];
  logic         out_ready_v [4];
  logic         in_ready_v  [4];
  logic         out_valid_v [4];
  logic [127:0] mix_out_v   [4];
  logic         busy_v      [4];

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CPC = (g == 1) ? 2 : (g == 2) ? 4 : 1;
    localparam bit INV = (g == 3) ? 1'b0 : 1'b1;
    mix_col_seq_if bus ();
    assign bus.in_valid    = in_valid_v[g];
    assign bus.mode        = mode_v[g];
    assign bus.mix_in      = mix_in_v[g];
    assign bus.out_ready   = out_ready_v[g];
    assign in_ready_v[g]   = bus.in_ready;
    assign out_valid_v[g]  = bus.out_valid;
    assign mix_out_v[g]    = bus.mix_out;
    assign busy_v[g]       = bus.busy;
    mix_col_seq #(.COLS_PER_CYCLE(CPC), .INV_EN(INV)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0] co [4];
    logic [7:0] a  [4];
    logic [7:0] b;
    logic [127:0] r;
    if (inv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     co = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[32*c+31-8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gm(co[(j - row + 4) % 4], a[j]);
        r[32*c+31-8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic int lat(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 4;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int k, input logic [127:0] din, input logic m,
                         input logic [127:0] exp, input string name);
    int cyc;
    cyc = 0;
    while (!in_ready_v[k] && cyc < 50) begin step(); cyc++; end
    in_valid_v[k] = 1'b1;
    mix_in_v[k]   = din;
    mode_v[k]     = m;
    step();
    in_valid_v[k] = 1'b0;
    mix_in_v[k]   = rnd128();
    mode_v[k]     = ~m;
    cyc = 0;
    while (!out_valid_v[k] && cyc < 20) begin step(); cyc++; end
    vectors++;
    if (cyc !== lat(k)) begin
      miscompares++;
      $display("FAIL %s latency inst %0d: got %0d clocks, expected %0d", name, k, cyc, lat(k));
    end
    vectors++;
    if (mix_out_v[k] !== exp) begin
      miscompares++;
      $display("FAIL %s data inst %0d: got %h, expected %h", name, k, mix_out_v[k], exp);
    end
    out_ready_v[k] = 1'b1;
    step();
    out_ready_v[k] = 1'b0;
    vectors++;
    if (out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s handshake inst %0d: out_valid=%b in_ready=%b, expected 0/1",
               name, k, out_valid_v[k], in_ready_v[k]);
    end
  endtask

  task automatic check_idle_reset(input string name);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_valid_v[k] !== 1'b0 || busy_v[k] !== 1'b0 || mix_out_v[k] !== 128'h0) begin
        miscompares++;
        $display("FAIL %s inst %0d: out_valid=%b busy=%b mix_out=%h, expected 0/0/0",
                 name, k, out_valid_v[k], busy_v[k], mix_out_v[k]);
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid_v[k] = 1'b0; mode_v[k] = 1'b0; mix_in_v[k] = '0; out_ready_v[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) step();
    check_idle_reset("reset_held");
    rst_n = 1'b1;
    repeat (2) step();
    check_idle_reset("reset_released");
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (in_ready_v[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_in_ready inst %0d: got %b, expected 1", k, in_ready_v[k]);
      end
    end
  endtask

  task automatic test_forward();
    logic [127:0] x;
    run_one(0, V1, 1'b0, R1, "fwd_vector");
    for (int i = 0; i < 4; i++) begin
      x = rnd128();
      run_one(0, x, 1'b0, model(x, 1'b0), "fwd_random");
    end
  endtask

  task automatic test_inverse();
    logic [127:0] x;
    run_one(0, R1, 1'b1, V1, "inv_vector");
    run_one(3, R1, 1'b1, model(R1, 1'b0), "inv_disabled_vector");
    for (int i = 0; i < 3; i++) begin
      x = rnd128();
      run_one(3, x, i[0], model(x, 1'b0), "inv_disabled_random");
      run_one(0, x, 1'b1, model(x, 1'b1), "inv_random");
    end
  endtask

  task automatic test_latency();
    logic [127:0] x, f;
    run_one(1, V1, 1'b0, R1, "cpc2_vector");
    run_one(2, V1, 1'b0, R1, "cpc4_vector");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        x = rnd128();
        f = model(x, 1'b0);
        run_one(k, x, 1'b0, f, "roundtrip_fwd");
        run_one(k, f, 1'b1, x, "roundtrip_inv");
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    in_valid_v[0] = 1'b1; mix_in_v[0] = V1; mode_v[0] = 1'b0;
    step();
    in_valid_v[0] = 1'b0;
    cyc = 0;
    while (!out_valid_v[0] && cyc < 20) begin step(); cyc++; end
    in_valid_v[0] = 1'b1;
    mix_in_v[0]   = rnd128();
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || mix_out_v[0] !== R1) begin
        miscompares++;
        $display("FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b mix_out=%h, expected 1/0/%h",
                 i, out_valid_v[0], in_ready_v[0], mix_out_v[0], R1);
      end
    end
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b1;
    step();
    out_ready_v[0] = 1'b0;
    vectors++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1 || mix_out_v[0] !== R1) begin
      miscompares++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b mix_out=%h, expected 0/1/%h",
               out_valid_v[0], in_ready_v[0], mix_out_v[0], R1);
    end
  endtask

  task automatic test_reset_midop();
    logic [127:0] x;
    in_valid_v[0] = 1'b1; mix_in_v[0] = V1; mode_v[0] = 1'b0;
    step();
    in_valid_v[0] = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || mix_out_v[0] !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_midop: out_valid=%b busy=%b mix_out=%h, expected 0/0/0",
               out_valid_v[0], busy_v[0], mix_out_v[0]);
    end
    #2;
    rst_n = 1'b1;
    step();
    check_idle_reset("reset_midop_exit");
    x = rnd128();
    run_one(0, x, 1'b0, model(x, 1'b0), "after_reset");
  endtask

  task automatic test_back_to_back(input int k);
    logic [127:0] q_exp [$];
    logic [127:0] d;
    logic [127:0] e;
    logic         m;
    int accepted, results, cyc, last;
    bit accept_now;
    accepted = 0; results = 0; cyc = 0; last = -1;
    d = rnd128();
    m = 1'($urandom);
    mix_in_v[k] = d; mode_v[k] = m; in_valid_v[k] = 1'b1; out_ready_v[k] = 1'b1;
    while (results < 100 && cyc < 3000) begin
      accept_now = in_valid_v[k] && in_ready_v[k];
      if (accept_now) begin
        q_exp.push_back(model(d, (k == 3) ? 1'b0 : m));
        accepted++;
      end
      if (out_valid_v[k]) begin
        e = (q_exp.size() > 0) ? q_exp.pop_front() : 128'hx;
        vectors++;
        if (mix_out_v[k] !== e) begin
          miscompares++;
          $display("FAIL b2b_data inst %0d result %0d: got %h, expected %h", k, results, mix_out_v[k], e);
        end
        if (last >= 0) begin
          vectors++;
          if (cyc - last !== lat(k) + 2) begin
            miscompares++;
            $display("FAIL b2b_period inst %0d result %0d: got %0d clocks, expected %0d",
                     k, results, cyc - last, lat(k) + 2);
          end
        end
        last = cyc;
        results++;
      end
      step();
      cyc++;
      if (accept_now) begin
        if (accepted < 100) begin
          d = rnd128();
          m = 1'($urandom);
          mix_in_v[k] = d;
          mode_v[k]   = m;
        end else begin
          in_valid_v[k] = 1'b0;
        end
      end
    end
    in_valid_v[k]  = 1'b0;
    out_ready_v[k] = 1'b0;
    vectors++;
    if (results !== 100) begin
      miscompares++;
      $display("FAIL b2b_count inst %0d: got %0d results, expected 100", k, results);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_latency();
    test_backpressure();
    test_reset_midop();
    for (int k = 0; k < 4; k++) test_back_to_back(k);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
